time_set_controller: RTL
========================

// Module: time_set_controller
// PURPOSE
//   Mode/set sequencer for the HH:MM:SS clock datapath. Consumes debounced key strobes and
//   drives the time counters: run-enable, load strobes with new hour/minute, clear of seconds.
//   Owns a shadow copy of the field being edited, plus a blink mask for the segment display driver.
// PARAMETERS
//   TIMEOUT_TICKS  10      ticks without a key in a SET state before abandoning the edit
//   REPEAT_DELAY   32768   clocks key_add held before auto-repeat starts (AUTO_REPEAT_EN only)
//   REPEAT_RATE    8192    clocks between auto-repeat increments (AUTO_REPEAT_EN only)
// PORTS
//   clock         in   1  system clock; all logic on its rising edge
//   reset         in   1  asynchronous, active-high reset
//   tick          in   1  1-cycle strobe at each wrap of the 16-bit clock prescaler
//   key_mode_down in   1  1-cycle strobe, debounced mode key press
//   key_add_down  in   1  1-cycle strobe, debounced add key press
//   key_add_level in   1  debounced add key level (1 = held)
//   hour_in       in   5  live hour counter, 0..23
//   minute_in     in   6  live minute counter, 0..59
//   run_en        out  1  1 = time counters advance
//   load_time     out  1  1-cycle commit strobe: counters take hour_out/minute_out, seconds := 0
//   hour_out      out  5  shadow hour; valid whenever load_time = 1
//   minute_out    out  6  shadow minute; valid whenever load_time = 1
//   state_out     out  2  current FSM state (encoding below)
//   blink_mask    out  2  [1] blank hour digits, [0] blank minute digits
// BEHAVIOUR
//   States: RUN=0, SET_HOUR=1, SET_MINUTE=2, STOP=3. All outputs registered.
//   Reset: state=RUN, run_en=1, load_time=0, hour_out=0, minute_out=0, blink_mask=0,
//     timeout and blink counters 0. Reset mid-edit discards shadow; no load_time is issued.
//   RUN: key_mode_down -> SET_HOUR, capture hour_in/minute_in into shadow same edge.
//     key_add_down -> STOP.
//   STOP: run_en=0; key_add_down -> RUN; key_mode_down -> SET_HOUR (capture as above).
//   SET_HOUR: run_en=0; key_add_down -> hour_out+1, 23 wraps to 0. key_mode_down -> SET_MINUTE.
//   SET_MINUTE: run_en=0; key_add_down -> minute_out+1, 59 wraps to 0.
//     key_mode_down -> RUN with load_time=1 for exactly one cycle, on the edge entering RUN.
//   Latency: state/shadow/run_en/load_time all change on the clock edge sampling the strobe.
//   Simultaneous key_mode_down and key_add_down: mode wins; add is dropped entirely.
//   Timeout: counter clears on any key strobe or state change, +1 per tick in SET states.
//     Reaching TIMEOUT_TICKS -> RUN, no load_time (edit abandoned). Saturates; never wraps.
//   Blink: blink_phase toggles on each tick; it is forced to 1 on any key strobe so edits
//     stay visible. blink_mask = {SET_HOUR & ~phase, SET_MINUTE & ~phase}; 0 in RUN/STOP.
//   tick coinciding with a key strobe: key handling wins; timeout counter clears.
// CONFIGURATION
//   AUTO_REPEAT_EN defined: in SET_HOUR/SET_MINUTE, key_add_level held continuously for
//     REPEAT_DELAY clocks produces one increment, then another every REPEAT_RATE clocks.
//     Repeat pulses behave exactly as key_add_down, including timeout clear. Release
//     or state change restarts the delay.
//   AUTO_REPEAT_EN undefined: key_add_level ignored; only key_add_down increments; no
//     repeat counter is synthesised.
// STRUCTURE
//   Package clock_ctrl_pkg: state encodings, HOUR_MAX=23, MINUTE_MAX=59, field widths,
//     blink_mask bit indices; the display driver imports the same package.
//   Sub-module key_repeat_gen (AUTO_REPEAT_EN only): level in, enable in, 1-cycle repeat
//     strobe out. Holds the delay/rate counter.
// TESTING
//   1 reset asserted -> run_en=1, state_out=0, load_time=0, blink_mask=0 on the next sample.
//   2 hour_in=13 minute_in=45; mode, add x11, mode, add x15, mode -> SET_HOUR hour_out=0
//     (13+11 wraps); minute_out=0 (45+15 wraps); one load_time pulse with 0/0; state RUN.
//   3 enter SET_HOUR, apply 10 ticks with no key -> RUN at 10th tick; load_time never asserted.
//   4 key_mode_down and key_add_down same cycle in SET_HOUR -> SET_MINUTE, hour_out unchanged.
//   5 RUN: add -> STOP, run_en=0; add -> RUN, run_en=1; no load_time.
//   6 AUTO_REPEAT_EN, SET_MINUTE, hold key_add_level REPEAT_DELAY+2*REPEAT_RATE clocks
//     -> minute_out +3; reset during hold -> minute_out=0, no load_time.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared encodings and field limits for the time-set controller and the display driver.
package clock_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_SET_HOUR   = 2'd1,
        ST_SET_MINUTE = 2'd2,
        ST_STOP       = 2'd3
    } state_t;

    localparam int HOUR_W     = 5;
    localparam int MINUTE_W   = 6;
    localparam int HOUR_MAX   = 23;
    localparam int MINUTE_MAX = 59;

    localparam int BLINK_HOUR_BIT   = 1;
    localparam int BLINK_MINUTE_BIT = 0;
endpackage

// File: rtl/time_set_controller_if.sv
// Key/time/counter-control bundle between the key front end, the controller and the time counters.
interface time_set_controller_if;
    import clock_ctrl_pkg::*;

    logic                tick;
    logic                key_mode_down;
    logic                key_add_down;
    logic                key_add_level;
    logic [HOUR_W-1:0]   hour_in;
    logic [MINUTE_W-1:0] minute_in;
    logic                run_en;
    logic                load_time;
    logic [HOUR_W-1:0]   hour_out;
    logic [MINUTE_W-1:0] minute_out;
    logic [1:0]          state_out;
    logic [1:0]          blink_mask;

    modport master (
        output tick, key_mode_down, key_add_down, key_add_level, hour_in, minute_in,
        input  run_en, load_time, hour_out, minute_out, state_out, blink_mask
    );

    modport slave (
        input  tick, key_mode_down, key_add_down, key_add_level, hour_in, minute_in,
        output run_en, load_time, hour_out, minute_out, state_out, blink_mask
    );
endinterface

// File: rtl/key_repeat_gen.sv
// Auto-repeat strobe generator for a held key; only built when AUTO_REPEAT_EN is defined.
`ifdef AUTO_REPEAT_EN
module key_repeat_gen #(
    parameter int DELAY = 32768,
    parameter int RATE  = 8192
) (
    input  logic clock,
    input  logic reset,
    input  logic level,
    input  logic enable,
    output logic strobe
);
    localparam int MAXC  = (DELAY > RATE) ? DELAY : RATE;
    localparam int CNT_W = $clog2(MAXC + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic             repeating;
    logic             active;

    // First strobe after DELAY held clocks, then one every RATE clocks.
    assign active = level & enable;
    assign limit  = repeating ? CNT_W'(RATE - 1) : CNT_W'(DELAY - 1);
    assign strobe = active & (cnt == limit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            repeating <= 1'b0;
        end else if (!active) begin
            cnt       <= '0;
            repeating <= 1'b0;
        end else if (strobe) begin
            cnt       <= '0;
            repeating <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule
`endif

// File: rtl/time_set_controller.sv
// Mode/set sequencer for the HH:MM:SS clock: run/stop, hour/minute editing, commit, timeout, blink.
// Optional feature: AUTO_REPEAT_EN enables auto-repeat of a held add key in the SET states.
module time_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 10,
    parameter int REPEAT_DELAY  = 32768,
    parameter int REPEAT_RATE   = 8192
) (
    input  logic                 clock,
    input  logic                 reset,
    time_set_controller_if.slave bus
);
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_TICKS);

    function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] h);
        return (h == HOUR_W'(HOUR_MAX)) ? '0 : h + 1'b1;
    endfunction

    function automatic logic [MINUTE_W-1:0] inc_minute(input logic [MINUTE_W-1:0] m);
        return (m == MINUTE_W'(MINUTE_MAX)) ? '0 : m + 1'b1;
    endfunction

    state_t              state, state_n;
    logic [HOUR_W-1:0]   hour_q, hour_n;
    logic [MINUTE_W-1:0] minute_q, minute_n;
    logic [TO_W-1:0]     to_cnt, to_n;
    logic                phase, phase_n;
    logic                run_q, run_n;
    logic                load_q, load_n;
    logic [1:0]          mask_q, mask_n;
    logic                in_set, rep_pulse, add_evt, key_evt;

    assign in_set = (state == ST_SET_HOUR) || (state == ST_SET_MINUTE);

`ifdef AUTO_REPEAT_EN
    // A mode press always changes state in SET, so it restarts the repeat delay.
    key_repeat_gen #(
        .DELAY (REPEAT_DELAY),
        .RATE  (REPEAT_RATE)
    ) u_key_repeat_gen (
        .clock  (clock),
        .reset  (reset),
        .level  (bus.key_add_level),
        .enable (in_set & ~bus.key_mode_down),
        .strobe (rep_pulse)
    );
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
    logic unused_level;
    assign unused_level = bus.key_add_level;
    assign rep_pulse    = 1'b0;
`endif

    assign add_evt = bus.key_add_down | rep_pulse;
    assign key_evt = bus.key_mode_down | add_evt;

    always_comb begin
        state_n  = state;
        hour_n   = hour_q;
        minute_n = minute_q;
        load_n   = 1'b0;
        to_n     = to_cnt;
        phase_n  = phase;
        mask_n   = '0;
        if (bus.key_mode_down) begin
            unique case (state)
                ST_RUN, ST_STOP: begin
                    state_n  = ST_SET_HOUR;
                    hour_n   = bus.hour_in;
                    minute_n = bus.minute_in;
                end
                ST_SET_HOUR:   state_n = ST_SET_MINUTE;
                ST_SET_MINUTE: begin
                    state_n = ST_RUN;
                    load_n  = 1'b1;
                end
                default: ;
            endcase
        end else if (add_evt) begin
            unique case (state)
                ST_RUN:        state_n  = ST_STOP;
                ST_STOP:       state_n  = ST_RUN;
                ST_SET_HOUR:   hour_n   = inc_hour(hour_q);
                ST_SET_MINUTE: minute_n = inc_minute(minute_q);
                default: ;
            endcase
        end else if (bus.tick && in_set && (to_cnt >= TO_LAST)) begin
            state_n = ST_RUN;
        end

        if (key_evt || (state_n != state)) begin
            to_n = '0;
        end else if (bus.tick && in_set && (to_cnt != TO_SAT)) begin
            to_n = to_cnt + 1'b1;
        end

        if (key_evt) begin
            phase_n = 1'b1;
        end else if (bus.tick) begin
            phase_n = ~phase;
        end

        run_n = (state_n == ST_RUN);
        mask_n[BLINK_HOUR_BIT]   = (state_n == ST_SET_HOUR) & ~phase_n;
        mask_n[BLINK_MINUTE_BIT] = (state_n == ST_SET_MINUTE) & ~phase_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            hour_q   <= '0;
            minute_q <= '0;
            to_cnt   <= '0;
            phase    <= 1'b0;
            run_q    <= 1'b1;
            load_q   <= 1'b0;
            mask_q   <= '0;
        end else begin
            state    <= state_n;
            hour_q   <= hour_n;
            minute_q <= minute_n;
            to_cnt   <= to_n;
            phase    <= phase_n;
            run_q    <= run_n;
            load_q   <= load_n;
            mask_q   <= mask_n;
        end
    end

    assign bus.run_en     = run_q;
    assign bus.load_time  = load_q;
    assign bus.hour_out   = hour_q;
    assign bus.minute_out = minute_q;
    assign bus.state_out  = state;
    assign bus.blink_mask = mask_q;
endmodule
